// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with per-digit enable/dp/blink, PWM dimming and
// a pending/active digit buffer that swaps only on frame boundaries.
module ssd_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_LOG2    = 18,
  parameter int unsigned DIM_BITS     = 3,
  parameter int unsigned BLINK_FRAMES = 48
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_digits,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
  input  logic [NUM_DIGITS-1:0]   i_dp_in,
  input  logic [NUM_DIGITS-1:0]   i_blink_en,
  input  logic [DIM_BITS-1:0]     i_brightness,
  input  logic                    i_load,
  output logic                    o_load_pending,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_cathodes,
  output logic                    o_dp,
  output logic                    o_frame_done
);

  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned BlinkW = $clog2(BLINK_FRAMES + 1);
  localparam logic [IdxW-1:0]   LastIdx   = IdxW'(NUM_DIGITS - 1);
  localparam logic [BlinkW-1:0] LastBlink = BlinkW'(BLINK_FRAMES - 1);

  logic [SCAN_LOG2-1:0]    r_slot;
  logic [IdxW-1:0]         r_idx;
  logic [BlinkW-1:0]       r_blink_cnt;
  logic                    r_blink_off;
  logic [4*NUM_DIGITS-1:0] r_pend_digits, r_act_digits;
  logic [NUM_DIGITS-1:0]   r_pend_en, r_act_en;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_act_dp;
  logic [NUM_DIGITS-1:0]   r_pend_blink, r_act_blink;
  logic                    r_load_pending;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_cathodes;
  logic                    r_dp;
  logic                    r_frame_done;

  logic                    w_slot_wrap;
  logic                    w_frame_wrap;
  logic [DIM_BITS-1:0]     w_phase;
  logic                    w_lit;
  logic [3:0]              w_digit;
  logic [NUM_DIGITS-1:0]   w_an_onecold;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'b0000001;
      4'h1:    hex7 = 7'b1001111;
      4'h2:    hex7 = 7'b0010010;
      4'h3:    hex7 = 7'b0000110;
      4'h4:    hex7 = 7'b1001100;
      4'h5:    hex7 = 7'b0100100;
      4'h6:    hex7 = 7'b0100000;
      4'h7:    hex7 = 7'b0001111;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0000100;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b1100000;
      4'hC:    hex7 = 7'b0110001;
      4'hD:    hex7 = 7'b1000010;
      4'hE:    hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    w_slot_wrap  = &r_slot;
    w_frame_wrap = w_slot_wrap && (r_idx == LastIdx);
    w_phase      = r_slot[SCAN_LOG2-1 -: DIM_BITS];
    w_digit      = r_act_digits[{r_idx, 2'b00} +: 4];
    w_an_onecold = ~(NUM_DIGITS'(1) << r_idx);
    // Brightness is taken live; only the digit content is double-buffered.
    w_lit        = (w_phase <= i_brightness) && r_act_en[r_idx] &&
                   !(r_act_blink[r_idx] && r_blink_off);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_slot         <= '0;
      r_idx          <= '0;
      r_blink_cnt    <= '0;
      r_blink_off    <= 1'b0;
      r_pend_digits  <= '0;
      r_pend_en      <= '0;
      r_pend_dp      <= '0;
      r_pend_blink   <= '0;
      r_act_digits   <= '0;
      r_act_en       <= '0;
      r_act_dp       <= '0;
      r_act_blink    <= '0;
      r_load_pending <= 1'b0;
      r_an           <= '1;
      r_cathodes     <= '1;
      r_dp           <= 1'b1;
      r_frame_done   <= 1'b0;
    end else begin
      r_slot       <= r_slot + 1'b1;
      r_frame_done <= w_frame_wrap;
      if (w_slot_wrap) begin
        r_idx <= (r_idx == LastIdx) ? '0 : r_idx + 1'b1;
      end

      if (i_load) begin
        r_pend_digits <= i_digits;
        r_pend_en     <= i_digit_en;
        r_pend_dp     <= i_dp_in;
        r_pend_blink  <= i_blink_en;
      end

      if (w_frame_wrap) begin
        // A load coincident with the wrap bypasses pending and is shown at once.
        if (i_load) begin
          r_act_digits <= i_digits;
          r_act_en     <= i_digit_en;
          r_act_dp     <= i_dp_in;
          r_act_blink  <= i_blink_en;
        end else begin
          r_act_digits <= r_pend_digits;
          r_act_en     <= r_pend_en;
          r_act_dp     <= r_pend_dp;
          r_act_blink  <= r_pend_blink;
        end
        r_load_pending <= 1'b0;
        if (r_blink_cnt == LastBlink) begin
          r_blink_cnt <= '0;
          r_blink_off <= ~r_blink_off;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end else if (i_load) begin
        r_load_pending <= 1'b1;
      end

      if (w_lit) begin
        r_an       <= w_an_onecold;
        r_cathodes <= hex7(w_digit);
        r_dp       <= ~r_act_dp[r_idx];
      end else begin
        r_an       <= '1;
        r_cathodes <= '1;
        r_dp       <= 1'b1;
      end
    end
  end

  assign o_load_pending = r_load_pending;
  assign o_an           = r_an;
  assign o_cathodes     = r_cathodes;
  assign o_dp           = r_dp;
  assign o_frame_done   = r_frame_done;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl: 4 digits, 8-cycle slots, 32-cycle frames, 2-frame blink.
module tb_ssd_scan_ctrl;

  localparam int unsigned ND = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   digits;
  logic [3:0]    digit_en, dp_in, blink_en;
  logic [1:0]    brightness;
  logic          load;
  logic          lp;
  logic [3:0]    an;
  logic [6:0]    cath;
  logic          dp;
  logic          fd;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            lo_cnt[ND];
  int            dp_lo[ND];
  int            first_k[ND];
  logic [6:0]    cath_seen[ND];
  int            fd_cnt;
  logic          lp_seen;
  int            multi_lo = 0;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(
    .NUM_DIGITS  (4),
    .SCAN_LOG2   (3),
    .DIM_BITS    (2),
    .BLINK_FRAMES(2)
  ) u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_digits      (digits),
    .i_digit_en    (digit_en),
    .i_dp_in       (dp_in),
    .i_blink_en    (blink_en),
    .i_brightness  (brightness),
    .i_load        (load),
    .o_load_pending(lp),
    .o_an          (an),
    .o_cathodes    (cath),
    .o_dp          (dp),
    .o_frame_done  (fd)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Runs 32 edges, pulsing load before edge number load_at (1..32), and tallies outputs.
  task automatic run_frame(input int load_at);
    for (int d = 0; d < ND; d++) begin
      lo_cnt[d] = 0; dp_lo[d] = 0; first_k[d] = 0; cath_seen[d] = 7'h7F;
    end
    fd_cnt = 0;
    lp_seen = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      load = (k == load_at);
      tick();
      if (fd) fd_cnt++;
      if (lp) lp_seen = 1'b1;
      if ($countones(~an) > 1) multi_lo++;
      for (int d = 0; d < ND; d++) begin
        if (!an[d]) begin
          if (lo_cnt[d] == 0) first_k[d] = k;
          lo_cnt[d]++;
          cath_seen[d] = cath;
          if (!dp) dp_lo[d]++;
        end
      end
    end
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; digits = '0; digit_en = '0; dp_in = '0; blink_en = '0;
    brightness = 2'd3; load = 1'b0;
    ticks(2);
    check("rst_an", an, 4'hF);
    check("rst_cath", cath, 7'h7F);
    check("rst_dp", dp, 1);
    check("rst_lp", lp, 0);
    check("rst_fd", fd, 0);

    // Test 1: load right after reset, shown from frame 1.
    rst_n = 1'b1; digits = 16'h3A70; digit_en = 4'hF; dp_in = 4'b0010; load = 1'b1;
    tick();
    load = 1'b0;
    check("t1_lp_set", lp, 1);
    check("t1_an_blank", an, 4'hF);
    ticks(30);
    check("t1_lp_hold", lp, 1);
    check("t1_fd_low", fd, 0);
    tick();
    check("t1_lp_clr", lp, 0);
    check("t1_fd_pulse", fd, 1);
    run_frame(-1);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("t1_lo%0d", d), lo_cnt[d], 8);
      check($sformatf("t1_first%0d", d), first_k[d], 1 + 8 * d);
    end
    check("t1_cath0", cath_seen[0], 7'b0000001);
    check("t1_cath1", cath_seen[1], 7'b0001111);
    check("t1_cath2", cath_seen[2], 7'b0001000);
    check("t1_cath3", cath_seen[3], 7'b0000110);
    check("t1_dp0", dp_lo[0], 0);
    check("t1_dp1", dp_lo[1], 8);
    check("t1_dp3", dp_lo[3], 0);
    check("t1_fd_cnt", fd_cnt, 1);

    // Test 2: brightness 0 then 2.
    brightness = 2'd0;
    run_frame(-1);
    for (int d = 0; d < ND; d++) check($sformatf("t2_b0_lo%0d", d), lo_cnt[d], 2);
    brightness = 2'd2;
    run_frame(-1);
    for (int d = 0; d < ND; d++) check($sformatf("t2_b2_lo%0d", d), lo_cnt[d], 6);

    // Test 3: disable digit 2 via a mid-frame load.
    brightness = 2'd3; digit_en = 4'b1011;
    run_frame(16);
    check("t3_old_lo2", lo_cnt[2], 8);
    check("t3_lp_seen", lp_seen, 1);
    check("t3_lp_clr", lp, 0);
    run_frame(-1);
    check("t3_lo0", lo_cnt[0], 8);
    check("t3_lo1", lo_cnt[1], 8);
    check("t3_lo2", lo_cnt[2], 0);
    check("t3_lo3", lo_cnt[3], 8);
    check("t3_cath1", cath_seen[1], 7'b0001111);
    check("t3_cath3", cath_seen[3], 7'b0000110);

    // Test 4: mid-frame load keeps old content until wrap; wrap-edge load shows at once.
    digits = 16'h1111; digit_en = 4'hF; dp_in = 4'h0;
    run_frame(10);
    check("t4_old_lo2", lo_cnt[2], 0);
    check("t4_old_cath1", cath_seen[1], 7'b0001111);
    check("t4_lp_seen", lp_seen, 1);
    run_frame(-1);
    for (int d = 0; d < ND; d++) check($sformatf("t4_ones%0d", d), cath_seen[d], 7'b1001111);
    check("t4_lo2", lo_cnt[2], 8);
    check("t4_dp1", dp_lo[1], 0);
    digits = 16'h5555;
    run_frame(32);
    check("t4_wrap_lp", lp_seen, 0);
    check("t4_wrap_old3", cath_seen[3], 7'b1001111);
    run_frame(-1);
    check("t4_wrap_new0", cath_seen[0], 7'b0100100);
    check("t4_wrap_new2", cath_seen[2], 7'b0100100);

    // Test 5: blink digit 0; frames 10-11 off, 12-13 on, 14 off.
    blink_en = 4'b0001;
    run_frame(32);
    check("t5_f10_lo0", lo_cnt[0], 8);
    run_frame(-1);
    check("t5_f11_lo0", lo_cnt[0], 0);
    check("t5_f11_lo1", lo_cnt[1], 8);
    run_frame(-1);
    check("t5_f12_lo0", lo_cnt[0], 8);
    run_frame(-1);
    check("t5_f13_lo0", lo_cnt[0], 8);
    run_frame(-1);
    check("t5_f14_lo0", lo_cnt[0], 0);
    check("t5_f14_lo3", lo_cnt[3], 8);

    // Test 6: reset while digit 2 is lit and a load is pending.
    digits = 16'h9999; blink_en = 4'h0; load = 1'b1;
    tick();
    load = 1'b0;
    ticks(19);
    check("t6_an_d2", an, 4'b1011);
    check("t6_lp_pre", lp, 1);
    rst_n = 1'b0;
    tick();
    check("t6_rst_an", an, 4'hF);
    check("t6_rst_cath", cath, 7'h7F);
    check("t6_rst_dp", dp, 1);
    check("t6_rst_lp", lp, 0);
    check("t6_rst_fd", fd, 0);
    rst_n = 1'b1;
    tick();
    check("t6_zero_an", an, 4'hF);
    load = 1'b1;
    tick();
    load = 1'b0;
    ticks(7);
    check("t6_still_blank", an, 4'hF);
    ticks(23);
    check("t6_wrap_fd", fd, 1);
    tick();
    check("t6_restart_an", an, 4'b1110);
    check("t6_restart_cath", cath, 7'b0000100);

    check("one_anode_max", multi_lo, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
- Parametrised seven-segment display scanner. Replaces the fixed 8-digit, hard-wired DIV_CLK-slice scan logic in our top-level files.
- Time-multiplexes NUM_DIGITS hex digits onto shared cathodes with:
  - per-digit enable, decimal point and blink;
  - global PWM brightness;
  - tear-free double-buffered loading.
- Sits between the core design (game/divider) and the board An/Ca..Cg/Dp pins, clocked on sys_clk.

Parameters:
- NUM_DIGITS, 8, number of digits/anodes (2..16).
- SCAN_LOG2, 18, log2 of clock cycles per digit slot (100 MHz / 2^18 ≈ 381 Hz per digit).
- DIM_BITS, 3, brightness resolution; 1 ≤ DIM_BITS ≤ SCAN_LOG2.
- BLINK_FRAMES, 48, full frames per blink half-period (≥1).

Ports:
- Clk, input, 1, system clock (sys_clk).
- Reset, input, 1, synchronous, active-low reset.
- Digits, input, 4*NUM_DIGITS, hex nibbles; digit i = Digits[4i+3:4i].
- DigitEn, input, NUM_DIGITS, 1 = digit shown; 0 = anode never asserted.
- DpIn, input, NUM_DIGITS, 1 = decimal point lit on digit i.
- BlinkEn, input, NUM_DIGITS, 1 = digit i blanked during blink-off phase.
- Brightness, input, DIM_BITS, duty = (Brightness+1)/2^DIM_BITS.
- Load, input, 1, one-cycle strobe that captures Digits/DigitEn/DpIn/BlinkEn into the pending buffer.
- LoadPending, output, 1, high from the cycle after Load until the pending→active swap.
- An, output, NUM_DIGITS, anodes, active-low, registered.
- Cathodes, output, 7, {Ca..Cg}, active-low, registered.
- Dp, output, 1, decimal point, active-low, registered.
- FrameDone, output, 1, one-cycle pulse per completed frame.

Behaviour:
- Reset (Reset=0 at a Clk edge), applied the same whether idle or mid-frame:
  - slot counter = 0, digit index = 0, blink counter = 0, blink phase = on;
  - pending and active buffers = all zero;
  - LoadPending=0, An=all ones, Cathodes=7'b1111111, Dp=1, FrameDone=0.
- Slot counter: SCAN_LOG2 bits, free-running, wraps to 0.
  - On its wrap, index increments; index NUM_DIGITS-1 wraps to 0.
  - Frame = NUM_DIGITS * 2^SCAN_LOG2 cycles.
- FrameDone: 1 in the cycle after the edge where index wraps NUM_DIGITS-1 → 0.
- Double buffering:
  - Load captures the inputs into pending and sets LoadPending.
  - The swap happens at the same edge as the frame wrap: active ← pending, LoadPending ← 0.
  - Load on the frame-wrap edge: pending and active both take the current inputs; LoadPending stays 0.
  - Multiple Loads within one frame: last one wins.
- PWM:
  - phase = top DIM_BITS bits of the slot counter.
  - Digit is lit iff phase ≤ Brightness, DigitEn[index]=1, and not (BlinkEn[index]=1 and blink phase = off).
- Blink:
  - Blink counter counts frame wraps 0..BLINK_FRAMES-1.
  - On its wrap, blink phase toggles.
- Outputs are registered with 1-cycle latency from counter state.
  - Lit: An = one-cold at index; Cathodes = hex decode of active digit[index]; Dp = ~active DpIn[index].
  - Unlit: An = all ones, Cathodes = 7'b1111111, Dp = 1.
- Hex decode (abcdefg, 0=on): 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100, 5:0100100, 6:0100000, 7:0001111, 8:0000000, 9:0000100, A:0001000, B:1100000, C:0110001, D:1000010, E:0110000, F:0111000.
- At most one anode is low in any cycle. Brightness changes take effect immediately, without buffering.

Test Plan:
Bench parameters: NUM_DIGITS=4, SCAN_LOG2=3, DIM_BITS=2, BLINK_FRAMES=2; frame = 32 cycles.
1. Reset, then Load with Digits=16'h3A70, DigitEn=4'hF, DpIn=4'b0010, Brightness=3 → LoadPending=1 until the first frame wrap. Next frame:
   - An cycles 1110,1101,1011,0111, each for 8 cycles;
   - Cathodes 0000001, 0001111, 0001000, 0000110;
   - Dp=0 only while An=1101;
   - FrameDone pulses every 32 cycles.
2. Brightness=0 → each anode low for exactly 2 of 8 slot cycles (phase 0); Brightness=2 → 6 of 8.
3. DigitEn=4'b1011 loaded → An[2] never low; all other digits unchanged.
4. Load Digits=16'h1111 mid-frame → display keeps old digits until the wrap, then shows 1s. Load asserted exactly on the wrap edge → new digits shown immediately; LoadPending stays 0.
5. BlinkEn=4'b0001 → digit 0 lit for frames 0–1, dark for frames 2–3, and repeating; digits 1–3 unaffected.
6. Reset (Reset=0) asserted mid-slot on digit 2 → next edge: An=1111, Cathodes=1111111, Dp=1, LoadPending=0. After release, scan restarts at digit 0 with active digits zeroed.
